watch_core_alarm: RTL and testbench
===================================

# watch_core_alarm

Parametrised timekeeping datapath: a prescaled sub-second counter cascaded into sec/min/hour fields, with a configurable sub-second rate and per-field inc/dec adjust that wraps within the field in both directions. It adds a hh:mm alarm register with its own adjust path, a 12/24-hour display mode and a run/hold control. It sits between the watch control FSM, which drives adjust select, inc/dec pulses and mode bits, and the FND/UART display formatters, which consume the time outputs.

## Interface
- CLK_FREQ, 100_000_000, input clock frequency in Hz
- SUBSEC_HZ, 100, sub-second tick rate; DIV = CLK_FREQ/SUBSEC_HZ, must be an integer ≥ 2
- SUBSEC_W, $clog2(SUBSEC_HZ), localparam, width of `msec`

- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- run  in  1  1 = time advances; 0 = prescaler and time hold
- clear  in  1  zero prescaler and all time fields; alarm registers untouched
- adj_sel  in  3  one-hot field select: [2]=sec, [1]=min, [0]=hour; 0 or multi-hot = no adjust
- adj_alarm  in  1  0 = inc/dec act on time, 1 = on alarm registers
- inc  in  1  single-cycle pulse, +1 on the selected field
- dec  in  1  single-cycle pulse, −1 on the selected field
- mode_12h  in  1  0 = hour output 0–23, 1 = 1–12
- alarm_en  in  1  enables `alarm_hit`
- msec  out  SUBSEC_W  sub-second count, 0..SUBSEC_HZ−1
- sec  out  6  0..59
- min  out  6  0..59
- hour  out  5  display hour per `mode_12h`
- pm  out  1  internal hour ≥ 12, valid in both modes
- alarm_min  out  6  alarm minute, 0..59
- alarm_hour  out  5  alarm hour, internal 0..23 (display conversion is done downstream)
- sec_tick  out  1  one-cycle pulse on each natural sec increment
- alarm_hit  out  1  one-cycle alarm pulse

## Operation
- Internal hour is always kept 0–23. The 12h mapping is combinational from the register: 0→12 with pm=0, 1–11 unchanged with pm=0, 12→12 with pm=1, 13–23→1–11 with pm=1.
- Prescaler counts 0..DIV−1 while run=1 and wraps at DIV−1. The wrap cycle is the sub-second tick.
- On the tick, msec increments; msec wrap (SUBSEC_HZ−1→0) carries to sec. The carry ripples sec 59→0 into min, and min 59→0 into hour. Hour 23→0 wraps with no carry out.
- All carries resolve on the same edge, so 23:59:59.(max) goes to 00:00:00.0 on one edge.
- Adjust, with exactly one adj_sel bit set and exactly one of inc/dec high:
  - The selected field goes ±1 and wraps inside the field only: 59↔0, 23↔0. It never carries to neighbouring fields.
  - inc and dec both high: no change.
- In an adjust cycle, the selected field ignores any natural carry into it that cycle. Lower fields still advance normally, and the carry out of the adjusted field is suppressed.
- Adjust works regardless of run.
- adj_alarm=1 routes inc/dec to alarm_min (adj_sel[1]) or alarm_hour (adj_sel[0]). adj_sel[2] is ignored in this case. Time fields are unaffected and keep running.
- Priority per cycle: rst > clear > adjust > natural count.
- alarm_hit is registered and asserts for exactly one cycle when all of the following hold:
  - alarm_en=1;
  - the previous edge produced hour==alarm_hour, min==alarm_min, sec==0, msec==0 by a natural tick.
- alarm_hit never fires when the match is reached by adjust, clear, or alarm-register edits.

## Timing
- Reset values:
  - prescaler, msec, sec, min, internal hour, alarm_min, alarm_hour, sec_tick, alarm_hit: all 0;
  - pm=0;
  - hour output = 0 in 24h mode, 12 in 12h mode.
- With run held at 1 from reset release, the first msec increment happens at edge DIV, and then every DIV cycles.
- run 1→0 freezes the prescaler value. Resuming continues from the frozen count, with no partial-period loss.
- inc/dec to field update: 1 edge. Time outputs are registers; hour and pm add combinational mapping only.
- sec_tick is high in the same cycle that sec shows its new value. It is not asserted for adjusts or clear.
- alarm_hit is high in the cycle after the outputs first show the matching hh:mm:00.0.
- clear mid-count: the next cycle shows all zeros, and the prescaler restarts from 0.
- rst mid-operation: every register returns to its reset value on that edge.

## Test plan
- Carry chain, CLK_FREQ=1000, SUBSEC_HZ=100 (DIV=10): run=1 from reset → msec=1 at cycle 10, sec=1 and sec_tick=1 at cycle 1000. Then force 23:59:59.99 via adjust → next tick gives 00:00:00.00 and pm=0.
- Adjust wrap: adj_sel=3'b100, dec with sec=0 → sec=59 and min unchanged. adj_sel=3'b001, inc with hour=23 → hour=0. inc+dec together → no change. adj_sel=3'b011 with inc → no change.
- Adjust/tick collision: sec=10, msec=99, inc on sec coincides with the tick → sec=11 (not 12), msec=0.
- 12h mode: internal hour 0, 11, 12, 13, 23 with mode_12h=1 → hour/pm = 12/0, 11/0, 12/1, 1/1, 11/1.
- Alarm: alarm set to 01:02 via adj_alarm path, time adjusted to 01:01:59.99, alarm_en=1 → alarm_hit is a single-cycle pulse one cycle after 01:02:00.00. Repeat with alarm_en=0 → no pulse. Adjust min directly onto 01:02 with sec=0, msec=0 → no pulse.
- run/clear/reset: run=0 for 37 cycles mid-period → msec update delayed by exactly 37 cycles. clear concurrent with inc → all time fields 0, alarm regs retained. rst → all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/watch_core_alarm.sv
// watch_core_alarm: prescaled hh:mm:ss.sub timekeeper with field adjust, 12/24h display, hh:mm alarm
module watch_core_alarm #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int SUBSEC_HZ = 100,
  localparam int SUBSEC_W = $clog2(SUBSEC_HZ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                clear,
  input  logic [2:0]          adj_sel,
  input  logic                adj_alarm,
  input  logic                inc,
  input  logic                dec,
  input  logic                mode_12h,
  input  logic                alarm_en,
  output logic [SUBSEC_W-1:0] msec,
  output logic [5:0]          sec,
  output logic [5:0]          min,
  output logic [4:0]          hour,
  output logic                pm,
  output logic [5:0]          alarm_min,
  output logic [4:0]          alarm_hour,
  output logic                sec_tick,
  output logic                alarm_hit
);
  localparam int DIV = CLK_FREQ / SUBSEC_HZ;
  localparam int PW = $clog2(DIV);

  function automatic logic [5:0] step60(input logic [5:0] v, input logic up);
    return up ? (v == 6'd59 ? 6'd0 : v + 6'd1) : (v == 6'd0 ? 6'd59 : v - 6'd1);
  endfunction

  function automatic logic [4:0] step24(input logic [4:0] v, input logic up);
    return up ? (v == 5'd23 ? 5'd0 : v + 5'd1) : (v == 5'd0 ? 5'd23 : v - 5'd1);
  endfunction

  logic [PW-1:0] presc;
  logic [4:0] hour_r;
  logic roll, tick, ms_wrap, adj, t_adj, adj_s, adj_m, adj_h, c_s, c_m;

  always_comb begin
    tick = run && presc == PW'(DIV - 1);
    ms_wrap = tick && msec == SUBSEC_W'(SUBSEC_HZ - 1);
    adj = $onehot(adj_sel) && (inc ^ dec);
    t_adj = adj && !adj_alarm;
    adj_s = t_adj && adj_sel[2];
    adj_m = t_adj && adj_sel[1];
    adj_h = t_adj && adj_sel[0];
    c_s = ms_wrap && sec == 6'd59 && !adj_s;
    c_m = c_s && min == 6'd59 && !adj_m;
  end

  assign hour = mode_12h && hour_r == 5'd0 ? 5'd12 : mode_12h && hour_r > 5'd12 ? hour_r - 5'd12 : hour_r;
  assign pm = hour_r >= 5'd12;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      msec <= '0;
      sec <= '0;
      min <= '0;
      hour_r <= '0;
      alarm_min <= '0;
      alarm_hour <= '0;
      sec_tick <= 1'b0;
      alarm_hit <= 1'b0;
      roll <= 1'b0;
    end else begin
      alarm_hit <= roll && alarm_en && hour_r == alarm_hour && min == alarm_min;
      if (clear) begin
        presc <= '0;
        msec <= '0;
        sec <= '0;
        min <= '0;
        hour_r <= '0;
        sec_tick <= 1'b0;
        roll <= 1'b0;
      end else begin
        if (run) presc <= tick ? '0 : presc + 1'b1;
        if (tick) msec <= ms_wrap ? '0 : msec + 1'b1;
        sec <= adj_s ? step60(sec, inc) : ms_wrap ? step60(sec, 1'b1) : sec;
        min <= adj_m ? step60(min, inc) : c_s ? step60(min, 1'b1) : min;
        hour_r <= adj_h ? step24(hour_r, inc) : c_m ? step24(hour_r, 1'b1) : hour_r;
        sec_tick <= ms_wrap && !adj_s;
        roll <= c_s && !t_adj;
        if (adj && adj_alarm && adj_sel[1]) alarm_min <= step60(alarm_min, inc);
        if (adj && adj_alarm && adj_sel[0]) alarm_hour <= step24(alarm_hour, inc);
      end
    end
  end
endmodule

// File: tb/tb_watch_core_alarm.sv
// tb_watch_core_alarm: random + directed stimulus vs. a day-count reference model, queue scoreboard
module tb_watch_core_alarm;
  localparam int DIV = 10;
  localparam int DAY = 8_640_000;

  typedef struct {
    int ms, s, mi, h, pm, am, ah, st, hit;
  } exp_t;

  logic clk = 1'b0;
  logic rst, run, clear, adj_alarm, inc, dec, mode_12h, alarm_en;
  logic [2:0] adj_sel;
  logic [6:0] msec;
  logic [5:0] sec, min, alarm_min;
  logic [4:0] hour, alarm_hour;
  logic pm, sec_tick, alarm_hit;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  logic w_run = 1'b0, w_m12 = 1'b0, w_aen = 1'b0;
  int m_presc = 0, m_t = 0, m_am = 0, m_ah = 0, m_st = 0, m_hit = 0, m_pend = 0;

  watch_core_alarm #(.CLK_FREQ(1000), .SUBSEC_HZ(100)) dut (
    .clk(clk), .rst(rst), .run(run), .clear(clear), .adj_sel(adj_sel),
    .adj_alarm(adj_alarm), .inc(inc), .dec(dec), .mode_12h(mode_12h),
    .alarm_en(alarm_en), .msec(msec), .sec(sec), .min(min), .hour(hour),
    .pm(pm), .alarm_min(alarm_min), .alarm_hour(alarm_hour),
    .sec_tick(sec_tick), .alarm_hit(alarm_hit)
  );

  always #5 clk = ~clk;

  function automatic int wrap(int v, logic up, int n);
    return up ? (v + 1) % n : (v + n - 1) % n;
  endfunction

  function automatic int comp(int h, int mi, int s, int ms);
    return ((h * 60 + mi) * 60 + s) * 100 + ms;
  endfunction

  function void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, a, e);
    end
  endfunction

  task automatic cyc(input logic r, input logic cl, input logic [2:0] sel,
                     input logic aa, input logic i, input logic d);
    exp_t e;
    int ms, s, mi, h, tn, nms, ns, nmi, h24;
    logic tk, adj, tadj, nxt_hit;
    @(negedge clk);
    rst = r; clear = cl; adj_sel = sel; adj_alarm = aa; inc = i; dec = d;
    run = w_run; mode_12h = w_m12; alarm_en = w_aen;
    if (r) begin
      m_presc = 0; m_t = 0; m_am = 0; m_ah = 0; m_st = 0; m_hit = 0; m_pend = 0;
    end else begin
      nxt_hit = m_pend != 0 && w_aen && (m_t / 6000 == m_ah * 60 + m_am);
      adj = $countones(sel) == 1 && i != d;
      tadj = adj && !aa;
      if (cl) begin
        m_presc = 0; m_t = 0; m_st = 0; m_pend = 0;
      end else begin
        tk = w_run && m_presc == DIV - 1;
        if (w_run) m_presc = (m_presc + 1) % DIV;
        ms = m_t % 100; s = (m_t / 100) % 60; mi = (m_t / 6000) % 60; h = m_t / 360000;
        tn = tk ? (m_t + 1) % DAY : m_t;
        nms = tn % 100; ns = (tn / 100) % 60; nmi = (tn / 6000) % 60;
        m_st = int'(tk && ms == 99 && !(tadj && sel[2]));
        if (tadj && sel[2]) tn = comp(h, mi, wrap(s, i, 60), nms);
        else if (tadj && sel[1]) tn = comp(h, wrap(mi, i, 60), ns, nms);
        else if (tadj && sel[0]) tn = comp(wrap(h, i, 24), nmi, ns, nms);
        m_pend = int'(tk && !tadj && tn % 6000 == 0);
        m_t = tn;
        if (adj && aa && sel[1]) m_am = wrap(m_am, i, 60);
        if (adj && aa && sel[0]) m_ah = wrap(m_ah, i, 24);
      end
      m_hit = int'(nxt_hit);
    end
    h24 = m_t / 360000;
    e.ms = m_t % 100; e.s = (m_t / 100) % 60; e.mi = (m_t / 6000) % 60;
    e.h = w_m12 ? (h24 % 12 == 0 ? 12 : h24 % 12) : h24;
    e.pm = int'(h24 >= 12); e.am = m_am; e.ah = m_ah; e.st = m_st; e.hit = m_hit;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic adjust(input logic [2:0] sel, input logic aa, input logic up);
    cyc(1'b0, 1'b0, sel, aa, up, !up);
  endtask

  task automatic sec_to_59();
    for (int k = 0; k < 62 && (m_t / 100) % 60 != 59; k++) adjust(3'b100, 1'b0, 1'b0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("msec", 32'(msec), e.ms);
      chk("sec", 32'(sec), e.s);
      chk("min", 32'(min), e.mi);
      chk("hour", 32'(hour), e.h);
      chk("pm", 32'(pm), e.pm);
      chk("alarm_min", 32'(alarm_min), e.am);
      chk("alarm_hour", 32'(alarm_hour), e.ah);
      chk("sec_tick", 32'(sec_tick), e.st);
      chk("alarm_hit", 32'(alarm_hit), e.hit);
    end
  end

  initial begin
    rst = 1'b1; run = 1'b0; clear = 1'b0; adj_sel = 3'b000; adj_alarm = 1'b0;
    inc = 1'b0; dec = 1'b0; mode_12h = 1'b0; alarm_en = 1'b0;
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    w_run = 1'b1;
    idle(1000);
    adjust(3'b001, 1'b0, 1'b0);
    adjust(3'b010, 1'b0, 1'b0);
    sec_to_59();
    idle(1100);
    w_run = 1'b0;
    cyc(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    adjust(3'b100, 1'b0, 1'b0);
    adjust(3'b001, 1'b0, 1'b0);
    adjust(3'b001, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 3'b100, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 3'b011, 1'b0, 1'b1, 1'b0);
    w_run = 1'b1;
    for (int k = 0; k < 1200; k++)
      cyc(1'b0, 1'b0, (m_presc == DIV - 1 && m_t % 100 == 99) ? 3'b100 : 3'b000, 1'b0, 1'b1, 1'b0);
    w_run = 1'b0; w_m12 = 1'b1;
    repeat (24) adjust(3'b001, 1'b0, 1'b1);
    w_m12 = 1'b0; w_run = 1'b1;
    idle(5);
    w_run = 1'b0;
    idle(37);
    w_run = 1'b1;
    idle(20);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    w_run = 1'b0;
    adjust(3'b001, 1'b1, 1'b1);
    adjust(3'b010, 1'b1, 1'b1);
    adjust(3'b010, 1'b1, 1'b1);
    adjust(3'b001, 1'b0, 1'b1);
    adjust(3'b010, 1'b0, 1'b1);
    adjust(3'b100, 1'b0, 1'b0);
    w_aen = 1'b1; w_run = 1'b1;
    idle(1100);
    w_aen = 1'b0;
    adjust(3'b010, 1'b0, 1'b0);
    sec_to_59();
    idle(1100);
    w_run = 1'b0;
    cyc(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    w_aen = 1'b1;
    adjust(3'b001, 1'b0, 1'b1);
    adjust(3'b010, 1'b0, 1'b1);
    adjust(3'b010, 1'b0, 1'b1);
    idle(3);
    adjust(3'b010, 1'b0, 1'b1);
    adjust(3'b010, 1'b1, 1'b1);
    idle(3);
    w_run = 1'b1;
    idle(300);
    cyc(1'b0, 1'b1, 3'b100, 1'b0, 1'b1, 1'b0);
    idle(50);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    idle(3);
    for (int k = 0; k < 6000; k++) begin
      w_run = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 99) == 0) w_m12 = ~w_m12;
      if ($urandom_range(0, 99) == 0) w_aen = ~w_aen;
      cyc($urandom_range(0, 1999) == 0, $urandom_range(0, 499) == 0,
          $urandom_range(0, 7) == 0 ? 3'($urandom_range(0, 7)) : 3'b000,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("drain", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
